// File: rtl/wb_regfile.sv
// Writeback stage: writeback mux, 32-entry register file with bypassed
// read ports, and a register dump engine for the debug unit.
module wb_regfile #(
    parameter int PC_BITS        = 32,
    parameter int PROC_BITS      = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int REG_COUNT      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PROC_BITS-1:0]      i_alu_data,
    input  logic [PROC_BITS-1:0]      i_mem_data,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_RegWrite,
    input  logic                      i_MemtoReg,
    input  logic                      i_pc_to_reg,
    input  logic [PC_BITS-1:0]        i_pc_return,
    input  logic [REG_ADDRS_BITS-1:0] i_rs,
    input  logic [REG_ADDRS_BITS-1:0] i_rt,
    output logic [PROC_BITS-1:0]      o_rs_data,
    output logic [PROC_BITS-1:0]      o_rt_data,
    output logic [PROC_BITS-1:0]      o_wb_data,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    output logic                      o_dump_valid,
    output logic [PROC_BITS-1:0]      o_dump_data,
    output logic [REG_ADDRS_BITS-1:0] o_dump_addr,
    output logic                      o_dump_busy,
    output logic                      o_dump_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } dump_state_e;

    localparam logic [REG_ADDRS_BITS-1:0] LAST_ADDR =
        REG_ADDRS_BITS'(REG_COUNT - 1);
    localparam logic [REG_ADDRS_BITS-1:0] ADDR_ONE =
        REG_ADDRS_BITS'(1);

    logic [PROC_BITS-1:0] pc_ext;
    logic                 wr_en;

    logic [PROC_BITS-1:0] regs_q [REG_COUNT];
    logic [PROC_BITS-1:0] regs_d [REG_COUNT];

    dump_state_e               state_q, state_d;
    logic [REG_ADDRS_BITS-1:0] addr_q,  addr_d;
    logic [PROC_BITS-1:0]      data_q,  data_d;
    logic                      valid_q, valid_d;
    logic                      busy_q,  busy_d;
    logic                      done_q,  done_d;

    // Fit the return address to the datapath width.
    generate
        if (PC_BITS < PROC_BITS) begin : g_pc_zext
            assign pc_ext = {{(PROC_BITS - PC_BITS){1'b0}}, i_pc_return};
        end else begin : g_pc_trunc
            assign pc_ext = i_pc_return[PROC_BITS-1:0];
        end
    endgenerate

    // Writeback select: return address beats load data beats ALU.
    always_comb begin
        o_wb_data = i_alu_data;
        if (i_pc_to_reg) begin
            o_wb_data = pc_ext;
        end else if (i_MemtoReg) begin
            o_wb_data = i_mem_data;
        end
    end

    assign wr_en = enable && i_RegWrite && (i_rd != '0);

    // Next register-file contents; r0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[i_rd] = o_wb_data;
        end
    end

    // Register-file storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A with same-cycle write-through.
    always_comb begin
        if (i_rs == '0) begin
            o_rs_data = '0;
        end else if (wr_en && (i_rd == i_rs)) begin
            o_rs_data = o_wb_data;
        end else begin
            o_rs_data = regs_q[i_rs];
        end
    end

    // Read port B with same-cycle write-through.
    always_comb begin
        if (i_rt == '0) begin
            o_rt_data = '0;
        end else if (wr_en && (i_rd == i_rt)) begin
            o_rt_data = o_wb_data;
        end else begin
            o_rt_data = regs_q[i_rt];
        end
    end

    // Dump engine next state: load a word, hold it until accepted, repeat.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_dump_start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                data_d  = regs_q[addr_q];
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (i_dump_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Dump engine state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_dump_valid = valid_q;
    assign o_dump_data  = data_q;
    assign o_dump_addr  = addr_q;
    assign o_dump_busy  = busy_q;
    assign o_dump_done  = done_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the writeback value (ALU result, load data or PC return address) and writes it into the 32-entry general-purpose register file. It provides the two decode-stage read ports, with same-cycle write-through bypass. It also includes a debug dump engine that streams every register out over a valid/ready interface to the debug unit.

Parameters:
PC_BITS, 32, width of the PC return address
PROC_BITS, 32, datapath / register width
REG_ADDRS_BITS, 5, register address width
REG_COUNT, 32, number of registers (2**REG_ADDRS_BITS)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-low reset
enable  in  1  pipeline advance; gates register-file writes only
i_alu_data  in  PROC_BITS  ALU result from MEM/WB
i_mem_data  in  PROC_BITS  load data from MEM/WB
i_rd  in  REG_ADDRS_BITS  destination register
i_RegWrite  in  1  write request
i_MemtoReg  in  1  select load data
i_pc_to_reg  in  1  select PC return (JAL/JALR)
i_pc_return  in  PC_BITS  return address
i_rs  in  REG_ADDRS_BITS  read port A address
i_rt  in  REG_ADDRS_BITS  read port B address
o_rs_data  out  PROC_BITS  read port A data (combinational)
o_rt_data  out  PROC_BITS  read port B data (combinational)
o_wb_data  out  PROC_BITS  selected writeback value (combinational, for forwarding)
i_dump_start  in  1  request full register dump
i_dump_ready  in  1  debug unit accepts current word
o_dump_valid  out  1  dump word valid
o_dump_data  out  PROC_BITS  dump word (registered)
o_dump_addr  out  REG_ADDRS_BITS  register index of dump word
o_dump_busy  out  1  dump in progress (any state but IDLE)
o_dump_done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0; dump FSM = IDLE; o_dump_valid=0, o_dump_data=0, o_dump_addr=0, o_dump_busy=0, o_dump_done=0.
- Writeback mux priority:
  - i_pc_to_reg → i_pc_return, zero-extended if PC_BITS<PROC_BITS, else truncated to the low PROC_BITS;
  - else i_MemtoReg → i_mem_data;
  - else i_alu_data.
- Write: at posedge when enable && i_RegWrite && i_rd!=0, reg[i_rd] <= o_wb_data. Register 0 is never written and always reads 0.
- Read ports, for each port:
  - address 0 → 0;
  - else if enable && i_RegWrite && i_rd==address → o_wb_data (bypass, zero latency);
  - else reg[address].
- Dump FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: i_dump_start=1 → LOAD, o_dump_addr<=0. i_dump_start is ignored in every other state.
  - LOAD: o_dump_data <= reg[o_dump_addr], raw array content with no bypass; → SEND.
  - SEND: o_dump_valid=1. o_dump_data and o_dump_addr are held until i_dump_ready=1. On handshake: if o_dump_addr==REG_COUNT-1 → DONE, else o_dump_addr+1 → LOAD.
  - DONE: o_dump_done=1 for exactly one cycle → IDLE; o_dump_addr returns to 0.
- Dump latency: first o_dump_valid 2 cycles after the start cycle; each subsequent word ≥2 cycles after the previous handshake. A full dump with ready held high takes 2*REG_COUNT+1 cycles from start to the done pulse.
- Writes during a dump are permitted. A word reflects the register value at its LOAD cycle; a write in the same LOAD cycle is not captured.
- Reset mid-dump aborts immediately: valid drops, no done pulse.

Test Plan:
- Reset then read any rs/rt → 0; after release, write reg5=0xDEADBEEF (RegWrite=1, enable=1, MemtoReg=0, pc_to_reg=0) → next cycle o_rs_data(rs=5)=0xDEADBEEF.
- Mux priority: alu=1, mem=2, pc_return=3 with MemtoReg=1, pc_to_reg=1 → reg written with 3; with pc_to_reg=0 → 2.
- Bypass: same cycle as write of 0x12345678 to r7, rt=7 → o_rt_data=0x12345678 combinationally; with enable=0 → old value, and no write occurs.
- r0 protection: write 0xFFFFFFFF to rd=0 → rs=0 reads 0, no bypass.
- Dump: preload reg[i]=i*0x11, pulse start, ready=1 → 32 words with addr 0..31 and data i*0x11, first valid at start+2, done pulse at start+65; with ready toggling 1-of-3 cycles, words are held stable and none are lost or duplicated.
- Assert rst during SEND at addr 10 → valid=0, busy=0 immediately, no done pulse; a new start restarts at addr 0.
